// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU slice: instruction opcodes, the
// program-feeder FSM state encoding, and a small decode helper. The CPU
// control unit imports the same package, so both sides agree on opcodes.
package cpu16_pkg;

    localparam int INSTR_W = 16;

    // Instruction word: [8:6] opcode, [5:3] rx, [2:0] ry, [15:9] ignored.
    typedef enum logic [2:0] {
        MV   = 3'b000,
        MVI  = 3'b001,
        ADD  = 3'b010,
        SUB  = 3'b011,
        HALT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        EXEC    = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    // mvi carries its immediate in the following program word.
    function automatic logic is_two_word(opcode_t op);
        return (op == MVI);
    endfunction

endpackage

// File: rtl/prog_feeder_if.sv
// Host/CPU-facing bundle of the program feeder.
//   master: program loader + run control + CPU done flag (drives wr_*, start,
//           abort, done; observes din, run, busy, halted, err, pc)
//   slave : the prog_feeder itself
interface prog_feeder_if
    import cpu16_pkg::*;
#(
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic               start;
    logic               abort;
    logic               done;
    logic [INSTR_W-1:0] din;
    logic               run;
    logic               busy;
    logic               halted;
    logic               err;
    logic [AW-1:0]      pc;

    modport master (
        output wr_en, wr_addr, wr_data, start, abort, done,
        input  din, run, busy, halted, err, pc
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, abort, done,
        output din, run, busy, halted, err, pc
    );

endinterface

// File: rtl/prog_ram.sv
// Program storage, DEPTH x 16. One synchronous write port and two
// combinational read ports (the feeder reads pc and pc+1 together so an mvi
// immediate is available without an extra cycle). No reset: contents survive
// resetn.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : two read addresses
//   rdata  : two read data words
module prog_ram
    import cpu16_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [INSTR_W-1:0]      wdata,
    input  logic [1:0][AW-1:0]      raddr,
    output logic [1:0][INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = mem[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/prog_feeder.sv
// Program feeder: holds a small program and steps a CPU through it, one
// instruction at a time, using the CPU's run/done handshake.
//   clk, resetn : clock, synchronous active-low reset
//   bus.wr_*    : program load port (ignored while busy)
//   bus.start   : begin execution at address 0 (ignored while busy)
//   bus.abort   : stop execution immediately, flags untouched
//   bus.done    : CPU instruction-complete flag
//   bus.din     : word presented to the CPU data input
//   bus.run     : CPU run enable
//   bus.busy    : execution in progress (ISSUE/EXEC)
//   bus.halted  : sticky normal end (halt opcode or end of memory)
//   bus.err     : sticky timeout or malformed program (mvi in last word)
//   bus.pc      : address of the current instruction
module prog_feeder
    import cpu16_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 7
) (
    input  logic          clk,
    input  logic          resetn,
    prog_feeder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t              state_reg;
    logic [AW-1:0]       pc_reg;
    logic [WW-1:0]       wait_cnt_reg;
    logic                halted_reg;
    logic                err_reg;

    logic [1:0][AW-1:0]      rd_addr;
    logic [1:0][INSTR_W-1:0] rd_data;
    opcode_t                 cur_op;
    logic                    cur_mvi;
    logic                    mvi_at_end;
    logic                    issue_ok;
    logic                    busy;
    logic [AW:0]             pc_adv;
    logic [INSTR_W-1:0]      din_sel;
    logic                    run_sel;

    assign busy = (state_reg == ISSUE) || (state_reg == EXEC);

    // pc+1 wraps at the top of memory; harmless because an mvi in the last
    // word is rejected before its immediate would be used.
    assign rd_addr[0] = pc_reg;
    assign rd_addr[1] = pc_reg + AW'(1);

    prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (bus.wr_en && !busy),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign cur_op     = opcode_t'(rd_data[0][8:6]);
    assign cur_mvi    = is_two_word(cur_op);
    assign mvi_at_end = cur_mvi && (pc_reg == LAST_ADDR);
    // A halt or a truncated mvi is decoded in ISSUE but never presented.
    assign issue_ok   = (cur_op != HALT) && !mvi_at_end;
    // One extra bit so running off the end of memory is visible.
    assign pc_adv     = {1'b0, pc_reg} + (cur_mvi ? (AW+1)'(2) : (AW+1)'(1));

    always_comb begin
        din_sel = '0;
        run_sel = 1'b0;
        case (state_reg)
            ISSUE: begin
                if (issue_ok) begin
                    din_sel = rd_data[0];
                    run_sel = 1'b1;
                end
            end
            EXEC: begin
                run_sel = 1'b1;
                din_sel = cur_mvi ? rd_data[1] : rd_data[0];
            end
            default: begin
                din_sel = '0;
                run_sel = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            pc_reg       <= '0;
            wait_cnt_reg <= '0;
            halted_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else if (bus.abort) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg  <= ISSUE;
                        pc_reg     <= '0;
                        halted_reg <= 1'b0;
                        err_reg    <= 1'b0;
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= '0;
                    if (cur_op == HALT) begin
                        halted_reg <= 1'b1;
                        state_reg  <= DONE_ST;
                    end else if (mvi_at_end) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE_ST;
                    end else begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    // done is tested first so it wins over a same-cycle timeout
                    if (bus.done) begin
                        wait_cnt_reg <= '0;
                        if (pc_adv > {1'b0, LAST_ADDR}) begin
                            pc_reg     <= LAST_ADDR;
                            halted_reg <= 1'b1;
                            state_reg  <= DONE_ST;
                        end else begin
                            pc_reg    <= pc_adv[AW-1:0];
                            state_reg <= ISSUE;
                        end
                    end else if (wait_cnt_reg == WW'(TIMEOUT - 1)) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE_ST;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WW'(1);
                    end
                end
                DONE_ST: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.din    = din_sel;
    assign bus.run    = run_sel;
    assign bus.busy   = busy;
    assign bus.halted = halted_reg;
    assign bus.err    = err_reg;
    assign bus.pc     = pc_reg;

endmodule

// File: tb/tb_prog_feeder.sv
// Directed bench for prog_feeder (DEPTH=32, TIMEOUT=7). A small CPU model
// raises done a programmable number of run cycles after each issue.
module tb_prog_feeder;

    logic clk;
    logic resetn;

    prog_feeder_if #(.DEPTH(32)) bus ();

    prog_feeder #(
        .DEPTH   (32),
        .TIMEOUT (7)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // CPU model and activity monitors, evaluated mid-cycle.
    logic done_auto = 1'b0;
    logic auto_en   = 1'b0;
    int   auto_lat  = 2;
    int   auto_cnt  = 0;
    int   run_total = 0;
    int   din40_total = 0;

    assign bus.done = done_auto;

    always @(negedge clk) begin
        if (bus.run === 1'b1) run_total++;
        if (bus.din === 16'h0040) din40_total++;
        if (!auto_en || bus.run !== 1'b1) begin
            auto_cnt  = 0;
            done_auto = 1'b0;
        end else begin
            auto_cnt++;
            done_auto = (auto_cnt == auto_lat);
            if (done_auto) auto_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    int run_base;
    int din40_base;

    initial begin
        resetn      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        tick();
        tick();
        check("rst_run",    32'(bus.run),    32'd0);
        check("rst_din",    32'(bus.din),    32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_err",    32'(bus.err),    32'd0);
        check("rst_pc",     32'(bus.pc),     32'd0);
        resetn = 1'b1;
        tick();

        // mvi r0,5 then halt
        load(0, 16'h0040);
        load(1, 16'h0005);
        load(2, 16'h01C0);
        auto_en  = 1'b1;
        auto_lat = 2;
        run_base = run_total;
        pulse_start();
        check("mvi_issue_din", 32'(bus.din),  32'h0040);
        check("mvi_issue_run", 32'(bus.run),  32'd1);
        check("mvi_issue_busy",32'(bus.busy), 32'd1);
        tick();
        check("mvi_exec_din",  32'(bus.din),  32'h0005);
        check("mvi_exec_run",  32'(bus.run),  32'd1);
        tick();
        check("mvi_pc_next",   32'(bus.pc),   32'd2);
        check("halt_not_run",  32'(bus.run),  32'd0);
        check("halt_not_din",  32'(bus.din),  32'd0);
        tick();
        check("mvi_halted",    32'(bus.halted), 32'd1);
        check("mvi_err",       32'(bus.err),    32'd0);
        check("mvi_done_busy", 32'(bus.busy),   32'd0);
        tick();
        check("mvi_run_cycles", 32'(run_total - run_base), 32'd2);

        // add r0,r1 (4-cycle latency) then halt
        load(0, 16'h0081);
        load(1, 16'h01C0);
        auto_lat = 4;
        run_base = run_total;
        pulse_start();
        check("add_issue_pc",  32'(bus.pc),     32'd0);
        check("add_clr_halt",  32'(bus.halted), 32'd0);
        tick();
        check("add_exec_din",  32'(bus.din),    32'h0081);
        tick();
        tick();
        tick();
        check("add_pc_next",   32'(bus.pc),     32'd1);
        tick();
        check("add_halted",    32'(bus.halted), 32'd1);
        check("add_err",       32'(bus.err),    32'd0);
        tick();
        check("add_run_cycles", 32'(run_total - run_base), 32'd4);

        // mv r1,r0 with done never raised: timeout after 7 EXEC cycles
        load(0, 16'h0008);
        auto_en  = 1'b0;
        run_base = run_total;
        pulse_start();
        for (int i = 0; i < 7; i++) tick();
        check("to_exec7_run",  32'(bus.run),  32'd1);
        check("to_exec7_err",  32'(bus.err),  32'd0);
        tick();
        check("to_err",        32'(bus.err),    32'd1);
        check("to_run_off",    32'(bus.run),    32'd0);
        check("to_busy_off",   32'(bus.busy),   32'd0);
        check("to_halted",     32'(bus.halted), 32'd0);
        tick();
        check("to_run_cycles", 32'(run_total - run_base), 32'd8);

        // all-mv program reaching an mvi in the last word
        for (int i = 0; i < 31; i++) load(i, 16'h0000);
        load(31, 16'h0040);
        auto_en    = 1'b1;
        auto_lat   = 2;
        run_base   = run_total;
        din40_base = din40_total;
        pulse_start();
        wait_idle("mvi_end_bound", 200);
        check("mvi_end_err",    32'(bus.err),    32'd1);
        check("mvi_end_halted", 32'(bus.halted), 32'd0);
        check("mvi_end_pc",     32'(bus.pc),     32'd31);
        check("mvi_end_no40",   32'(din40_total - din40_base), 32'd0);
        check("mvi_end_runs",   32'(run_total - run_base),     32'd62);
        tick();

        // all-mv program running off the end of memory
        load(31, 16'h0000);
        run_base = run_total;
        pulse_start();
        wait_idle("eop_bound", 200);
        check("eop_halted", 32'(bus.halted), 32'd1);
        check("eop_err",    32'(bus.err),    32'd0);
        check("eop_pc",     32'(bus.pc),     32'd31);
        check("eop_runs",   32'(run_total - run_base), 32'd64);
        tick();
        pulse_abort();
        check("abort_keeps_halted", 32'(bus.halted), 32'd1);

        // abort mid-EXEC
        load(0, 16'h0081);
        auto_en = 1'b0;
        pulse_start();
        tick();
        tick();
        check("ab_pre_run", 32'(bus.run), 32'd1);
        pulse_abort();
        check("ab_run",  32'(bus.run),  32'd0);
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_din",  32'(bus.din),  32'd0);
        check("ab_err",  32'(bus.err),  32'd0);

        // write while busy is ignored, then rerun shows mem[0] intact
        pulse_start();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_data = 16'hFFFF;
        tick();
        bus.wr_en   = 1'b0;
        tick();
        pulse_abort();
        pulse_start();
        check("busy_wr_ignored", 32'(bus.din), 32'h0081);
        pulse_abort();
        check("ab2_busy", 32'(bus.busy), 32'd0);

        // reset mid-EXEC of the second instruction
        auto_en  = 1'b1;
        auto_lat = 4;
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("rs_pre_pc",  32'(bus.pc),  32'd1);
        check("rs_pre_run", 32'(bus.run), 32'd1);
        resetn = 1'b0;
        tick();
        check("rs_run",    32'(bus.run),    32'd0);
        check("rs_busy",   32'(bus.busy),   32'd0);
        check("rs_din",    32'(bus.din),    32'd0);
        check("rs_pc",     32'(bus.pc),     32'd0);
        check("rs_halted", 32'(bus.halted), 32'd0);
        check("rs_err",    32'(bus.err),    32'd0);
        resetn  = 1'b1;
        auto_en = 1'b0;
        tick();
        pulse_start();
        check("rs_mem_kept", 32'(bus.din), 32'h0081);
        pulse_abort();
        check("rs_ab_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_feeder.md
PROG_FEEDER -- requirements
Module: prog_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of 16-bit program words.
REQ-002 The block SHALL have parameter TIMEOUT, default 7, giving the maximum cycles to wait for done after an instruction is issued.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: program-load write strobe.
REQ-006 The block SHALL have port wr_addr, input, log2(DEPTH) bits: program-load word address.
REQ-007 The block SHALL have port wr_data, input, 16 bits: program-load data word.
REQ-008 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins execution at address 0.
REQ-009 The block SHALL have port abort, input, 1 bit: stops execution.
REQ-010 The block SHALL have port done, input, 1 bit: CPU instruction-complete flag.
REQ-011 The block SHALL have port din, output, 16 bits: word driven to the CPU data input.
REQ-012 The block SHALL have port run, output, 1 bit: CPU run enable.
REQ-013 The block SHALL have port busy, output, 1 bit: execution in progress.
REQ-014 The block SHALL have port halted, output, 1 bit: sticky normal-end flag.
REQ-015 The block SHALL have port err, output, 1 bit: sticky timeout or malformed-program flag.
REQ-016 The block SHALL have port pc, output, log2(DEPTH) bits: address of the current instruction.

Function
REQ-017 Instruction format: bits [8:6] opcode (000 mv, 001 mvi, 010 add, 011 sub, 111 halt), [5:3] rx, [2:0] ry, [15:9] ignored.
REQ-018 The FSM SHALL have states IDLE, ISSUE, EXEC, DONE_ST.
- IDLE → ISSUE on start, setting pc=0 and clearing halted and err.
REQ-019 ISSUE lasts one cycle.
- din=mem[pc], run=1.
- The CPU latches IR at the closing edge.
- A halt opcode SHALL NOT be issued; it goes instead to DONE_ST with halted=1 and run=0.
REQ-020 EXEC drives run=1.
- For mvi: din=mem[pc+1], held for the whole of EXEC.
- For other opcodes: din=mem[pc].
REQ-021 EXEC exit on done sampled high:
- pc advances by 2 for mvi, by 1 otherwise.
- Next state is ISSUE.
- Latency: mv/mvi = 2 cycles per instruction; add/sub = 4 cycles per instruction.
REQ-022 A wait counter SHALL count EXEC cycles.
- If it reaches TIMEOUT without done: err=1, then DONE_ST.
- If done and timeout occur in the same cycle, done wins.
REQ-023 An mvi at address DEPTH-1 (no immediate word) SHALL set err=1 and go to DONE_ST without issuing.
REQ-024 End of program:
- If pc advances past DEPTH-1 (no wrap), the block SHALL set halted=1 and go to DONE_ST.
- pc SHALL saturate and SHALL NOT wrap to 0.
REQ-025 DONE_ST: run=0, busy=0, and the block returns to IDLE the next cycle; halted and err hold until the next start or reset.
REQ-026 busy=1 in ISSUE and EXEC only.
REQ-027 start while busy SHALL be ignored.
REQ-028 wr_en while busy SHALL be ignored; when not busy, mem[wr_addr] SHALL be written at the edge.
REQ-029 abort SHALL take priority over every other event.
- From any state: next state IDLE, run=0, busy=0.
- halted and err are unchanged.
REQ-030 In IDLE, run=0 and din=0.

Reset
REQ-031 With resetn low at a clock edge:
- state=IDLE; run=0, din=0, busy=0, halted=0, err=0, pc=0; wait counter 0.
- Program memory SHALL NOT be cleared.
REQ-032 Reset SHALL take effect mid-instruction, dropping run the following cycle, and SHALL take priority over abort and start.

Structure
REQ-033 Opcode constants (MV, MVI, ADD, SUB, HALT) and the FSM state encoding SHALL live in shared package cpu16_pkg, also used by the CPU control unit.
REQ-034 Program storage SHALL be a sub-module prog_ram.
- DEPTH x 16.
- Synchronous write.
- Two combinational read ports: pc and pc+1.

Verification
REQ-035 Load [0x0040, 0x0005, 0x01C0], pulse start:
- ISSUE din=0x0040, then EXEC din=0x0005.
- Done in that cycle, then halted=1.
- run high for exactly 2 cycles.
REQ-036 Load [0x0081 (add r0,r1), 0x01C0], with the CPU model raising done 3 cycles after issue:
- pc 0→1.
- run high for exactly 4 cycles.
- halted=1, err=0.
REQ-037 Load [0x0008 (mv r1,r0)] with done never raised:
- err=1 after TIMEOUT=7 EXEC cycles.
- run=0 the next cycle.
REQ-038 Place 0x0040 at address 31 with DEPTH=32, start at an all-mv program that reaches it: err=1, and 0x0040 is never driven.
REQ-039 Mid-EXEC disturbances:
- Pulsing abort mid-EXEC SHALL give run=0 and busy=0 the next cycle.
- Driving resetn low mid-EXEC SHALL give all outputs 0 the next cycle.
- Program contents SHALL be retained after either.
REQ-040 wr_en with wr_addr=0 and wr_data=0xFFFF while busy SHALL leave mem[0] unchanged, checked by a rerun.
